// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised raster timing generator for arcade cores. Runs pixel/line
//   counters, produces registered blanking, sync and blanked RGB, applies
//   frame-synchronous H/V sync offsets with clamping, and emits one-cycle
//   line/frame strobes.
//
// Ports
//   clk_sys      system clock
//   RESET        synchronous active-high reset (works regardless of ce_pix)
//   ce_pix       pixel clock enable; nothing advances while low
//   hoffs        signed H sync offset, units of 2 pixels
//   voffs        signed V sync offset, units of 1 line
//   iRGB         core pixel for the current HPOS/VPOS
//   HPOS/VPOS    current counters, combinational from the counter registers
//   oRGB         registered pixel, forced to 0 while blanked
//   HBLK/VBLK    registered blanking
//   HSYN/VSYN    registered sync at polarity HS_POL/VS_POL
//   line_start   one clk_sys pulse after the ce_pix edge where hcnt wraps
//   frame_start  one clk_sys pulse after the ce_pix edge where both wrap
module video_timing_gen #(
  parameter int H_TOTAL      = 456,
  parameter int H_ACTIVE     = 336,
  parameter int H_SYNC_START = 360,
  parameter int H_SYNC_WIDTH = 24,
  parameter int V_TOTAL      = 262,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 240,
  parameter int V_SYNC_WIDTH = 3,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int RGB_W        = 8,
  parameter int OFFS_W       = 5
) (
  input  logic                         clk_sys,
  input  logic                         RESET,
  input  logic                         ce_pix,
  input  logic [OFFS_W-1:0]            hoffs,
  input  logic [OFFS_W-1:0]            voffs,
  input  logic [RGB_W-1:0]             iRGB,
  output logic [$clog2(H_TOTAL)-1:0]   HPOS,
  output logic [$clog2(V_TOTAL)-1:0]   VPOS,
  output logic [RGB_W-1:0]             oRGB,
  output logic                         HBLK,
  output logic                         VBLK,
  output logic                         HSYN,
  output logic                         VSYN,
  output logic                         line_start,
  output logic                         frame_start
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [OFFS_W-1:0] hoffs_l;
  logic [OFFS_W-1:0] voffs_l;
  logic              hblk_q, vblk_q, hsyn_q, vsyn_q;
  logic [RGB_W-1:0]  rgb_q;
  logic              ls_q, fs_q;

  logic h_last, v_last, h_blank, v_blank, hs_act, vs_act;

  // Sync window arithmetic is done in 32-bit signed so that offsets far
  // outside the blank interval clamp cleanly instead of wrapping.
  logic signed [31:0] hoffs_ext, voffs_ext;
  logic signed [31:0] hs_raw, vs_raw, hs_b, vs_b;
  logic signed [31:0] hpos_s, vpos_s;

  always_comb begin
    h_last  = (hcnt == HW'(H_TOTAL - 1));
    v_last  = (vcnt == VW'(V_TOTAL - 1));
    h_blank = (hcnt >= HW'(H_ACTIVE));
    v_blank = (vcnt >= VW'(V_ACTIVE));

    hoffs_ext = {{(32-OFFS_W){hoffs_l[OFFS_W-1]}}, hoffs_l};
    voffs_ext = {{(32-OFFS_W){voffs_l[OFFS_W-1]}}, voffs_l};
    hs_raw    = H_SYNC_START + 2 * hoffs_ext;
    vs_raw    = V_SYNC_START + voffs_ext;

    // Clamping keeps sync entirely inside the blank interval.
    hs_b = hs_raw;
    if (hs_raw < H_ACTIVE)                     hs_b = H_ACTIVE;
    else if (hs_raw > H_TOTAL - H_SYNC_WIDTH)  hs_b = H_TOTAL - H_SYNC_WIDTH;
    vs_b = vs_raw;
    if (vs_raw < V_ACTIVE)                     vs_b = V_ACTIVE;
    else if (vs_raw > V_TOTAL - V_SYNC_WIDTH)  vs_b = V_TOTAL - V_SYNC_WIDTH;

    hpos_s = {{(32-HW){1'b0}}, hcnt};
    vpos_s = {{(32-VW){1'b0}}, vcnt};
    hs_act = (hpos_s >= hs_b) && (hpos_s < hs_b + H_SYNC_WIDTH);
    vs_act = (vpos_s >= vs_b) && (vpos_s < vs_b + V_SYNC_WIDTH);
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      hcnt    <= '0;
      vcnt    <= '0;
      hblk_q  <= 1'b1;
      vblk_q  <= 1'b1;
      hsyn_q  <= ~HS_POL;
      vsyn_q  <= ~VS_POL;
      rgb_q   <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      hoffs_l <= hoffs;
      voffs_l <= voffs;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (ce_pix) begin
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? '0 : vcnt + VW'(1);
        end else begin
          hcnt <= hcnt + HW'(1);
        end
        // Outputs are taken from the pre-edge position: one pixel behind HPOS.
        hblk_q <= h_blank;
        vblk_q <= v_blank;
        rgb_q  <= (h_blank || v_blank) ? '0 : iRGB;
        hsyn_q <= hs_act ? HS_POL : ~HS_POL;
        vsyn_q <= vs_act ? VS_POL : ~VS_POL;
        ls_q   <= h_last;
        fs_q   <= h_last && v_last;
        // Offsets only change at the frame boundary, so sync never tears.
        if (h_last && v_last) begin
          hoffs_l <= hoffs;
          voffs_l <= voffs;
        end
      end
    end
  end

  assign HPOS        = hcnt;
  assign VPOS        = vcnt;
  assign oRGB        = rgb_q;
  assign HBLK        = hblk_q;
  assign VBLK        = vblk_q;
  assign HSYN        = hsyn_q;
  assign VSYN        = vsyn_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
